// File: rtl/exp_sum_accumulator.sv
// exp_sum_accumulator
// Softmax denominator stage. It sums one row of U1Q15 exponent samples into
// a 24-bit U9Q15 accumulator. At row close it converts the sum to U8Q8 with
// saturation and a floor of 0x0001. It holds the result for the log stage and
// generates a valid tag that lines up with the log stage's registered output.
module exp_sum_accumulator #(
   parameter int ROW_LEN    = 64,
   parameter int LN_LATENCY = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_exp_U1Q15,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      x_U8Q8,
   output logic             ln_valid,
   output logic [CNT_W-1:0] row_cnt,
   output logic             len_err
);

   typedef enum logic {ACC, HOLD} state_t;

   state_t                state;
   logic [23:0]           acc;
   logic [LN_LATENCY-1:0] ln_pipe;

   logic             accept;
   logic             at_bound;
   logic             row_end;
   logic             handshake;
   logic [CNT_W-1:0] cnt_next;
   logic [23:0]      sum;
   logic [16:0]      t;
   logic [15:0]      x_next;

   // in_ready is forced low during reset so that no sample is lost while the state is being cleared.
   assign in_ready  = rst_n && (state == ACC);
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign cnt_next  = row_cnt + 1'b1;
   assign at_bound  = (cnt_next == CNT_W'(ROW_LEN));
   assign row_end   = accept && (in_last || at_bound);

   // The sum includes the sample being accepted, so the closing sample contributes to the result.
   // 255 * 0xFFFF fits in 24 bits, so the accumulator does not wrap.
   assign sum = acc + {8'd0, in_exp_U1Q15};
   assign t   = sum[23:7];

   // U9Q8 to U8Q8 conversion. Values above 0xFFFF saturate, and zero is raised to one LSB because log(0) is undefined.
   // NOTE: x_next gets a default first, so every path assigns it and no latch is inferred.
   always_comb begin
      x_next = t[15:0];
      if (t[16])
         x_next = 16'hFFFF;
      else if (t == 17'd0)
         x_next = 16'h0001;
   end

   // Row FSM. ACC accumulates samples. HOLD presents the sum until the downstream handshake.
   // NOTE: state registers use non-blocking assignments so that every register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= 24'd0;
         row_cnt   <= '0;
         out_valid <= 1'b0;
         x_U8Q8    <= 16'h0000;
         len_err   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  acc     <= sum;
                  row_cnt <= cnt_next;
                  if (row_end) begin
                     x_U8Q8    <= x_next;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                     if (in_last != at_bound)
                        len_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  acc       <= 24'd0;
                  row_cnt   <= '0;
                  out_valid <= 1'b0;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

   // Delay line that carries the handshake event forward by the log stage latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ln_pipe <= '0;
      end else begin
         ln_pipe[0] <= handshake;
         for (int i = 1; i < LN_LATENCY; i++)
            ln_pipe[i] <= ln_pipe[i-1];
      end
   end

   assign ln_valid = ln_pipe[LN_LATENCY-1];

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// tb_exp_sum_accumulator
// Three instances of the design are built with ROW_LEN = 4, 255 and 1.
// They share the clock and reset.
// Expected sums, row counts and len_err values come from a plain arithmetic
// model of each row.
module tb_exp_sum_accumulator;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [NI];
   logic        in_last   [NI];
   logic        out_ready [NI];
   logic [15:0] in_exp    [NI];

   wire         in_ready_w  [NI];
   wire         out_valid_w [NI];
   wire         ln_valid_w  [NI];
   wire         len_err_w   [NI];
   wire  [15:0] x_w         [NI];
   wire  [7:0]  cnt_w       [NI];

   int unsigned passed = 0;
   int unsigned total  = 0;
   logic        exp_err [NI];
   logic [15:0] row_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      exp_sum_accumulator #(
         .ROW_LEN   ((g == 0) ? 4 : ((g == 1) ? 255 : 1)),
         .LN_LATENCY(2),
         .CNT_W     (8)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready_w[g]),
         .in_exp_U1Q15(in_exp[g]),
         .in_last     (in_last[g]),
         .out_valid   (out_valid_w[g]),
         .out_ready   (out_ready[g]),
         .x_U8Q8      (x_w[g]),
         .ln_valid    (ln_valid_w[g]),
         .row_cnt     (cnt_w[g]),
         .len_err     (len_err_w[g])
      );
   end

   function automatic int row_len_of(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 255 : 1);
   endfunction

   // Reference conversion of a row sum in U9Q15 to the value sent to the log stage.
   function automatic logic [15:0] model_x(input longint unsigned s);
      longint unsigned t;
      t = s / 128;
      if (t > 65535) return 16'hFFFF;
      if (t == 0)    return 16'h0001;
      return 16'(t);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
   endtask

   // Streams row_q into instance g at one sample per cycle. in_last is
   // asserted at index last_pos (-1 means never). The caller arranges for
   // the row to close on the final element of row_q.
   task automatic run_row(input int g, input int last_pos, input string tag);
      longint unsigned sum = 0;
      int n = row_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) check({tag, " in_ready"}, 32'(in_ready_w[g]), 1);
         in_valid[g] = 1'b1;
         in_exp[g]   = row_q[i];
         in_last[g]  = (i == last_pos);
         sum += row_q[i];
      end
      if ((last_pos == n - 1) != (n == row_len_of(g))) exp_err[g] = 1'b1;
      @(negedge clk);
      in_valid[g] = 1'b0;
      in_last[g]  = 1'b0;
      check({tag, " out_valid"}, 32'(out_valid_w[g]), 1);
      check({tag, " in_ready_hold"}, 32'(in_ready_w[g]), 0);
      check({tag, " x"}, 32'(x_w[g]), 32'(model_x(sum)));
      check({tag, " row_cnt"}, 32'(cnt_w[g]), 32'(n));
      check({tag, " len_err"}, 32'(len_err_w[g]), 32'(exp_err[g]));
   endtask

   // Holds off the handshake for wait_n cycles while offering an extra sample
   // that must be ignored. It then completes the handshake and checks the
   // timing of the ln_valid pulse.
   task automatic drain(input int g, input int wait_n, input string tag);
      logic [15:0] held;
      held = x_w[g];
      in_valid[g] = 1'b1;
      in_exp[g]   = 16'hFFFF;
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         check({tag, " bp_valid"}, 32'(out_valid_w[g]), 1);
         check({tag, " bp_x_stable"}, 32'(x_w[g]), 32'(held));
         check({tag, " bp_in_ready"}, 32'(in_ready_w[g]), 0);
         check({tag, " bp_ln"}, 32'(ln_valid_w[g]), 0);
      end
      @(negedge clk);
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      @(negedge clk);
      out_ready[g] = 1'b0;
      check({tag, " hs_out_valid"}, 32'(out_valid_w[g]), 0);
      check({tag, " hs_row_cnt"}, 32'(cnt_w[g]), 0);
      check({tag, " ln_early"}, 32'(ln_valid_w[g]), 0);
      check({tag, " x_kept"}, 32'(x_w[g]), 32'(held));
      @(negedge clk);
      check({tag, " ln_pulse"}, 32'(ln_valid_w[g]), 1);
      @(negedge clk);
      check({tag, " ln_end"}, 32'(ln_valid_w[g]), 0);
   endtask

   task automatic fill(input int n, input logic [15:0] v);
      row_q.delete();
      for (int i = 0; i < n; i++) row_q.push_back(v);
   endtask

   initial begin
      int n;
      int lp;
      rst_n = 1'b0;
      for (int g = 0; g < NI; g++) begin
         in_valid[g] = 1'b0; in_last[g] = 1'b0; out_ready[g] = 1'b0;
         in_exp[g] = 16'h0; exp_err[g] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      check("rst in_ready_low", 32'(in_ready_w[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check("rst in_ready", 32'(in_ready_w[g]), 1);
         check("rst out_valid", 32'(out_valid_w[g]), 0);
         check("rst x", 32'(x_w[g]), 0);
         check("rst ln_valid", 32'(ln_valid_w[g]), 0);
         check("rst len_err", 32'(len_err_w[g]), 0);
         check("rst row_cnt", 32'(cnt_w[g]), 0);
      end

      // Four samples of 1.0 give a sum of 4.0, which is 0x0400.
      fill(4, 16'h8000);
      run_row(0, -1, "ones4");
      check("ones4 x_const", 32'(x_w[0]), 32'h0400);
      drain(0, 0, "ones4");

      // Back-pressure: out_ready stays low for 5 cycles.
      fill(4, 16'h1234);
      run_row(0, 3, "bp");
      drain(0, 5, "bp");

      // Saturation on the 255-element instance.
      fill(255, 16'hFFFF);
      run_row(1, -1, "sat");
      check("sat x_const", 32'(x_w[1]), 32'hFFFF);
      drain(1, 1, "sat");

      // Floor on the single-element instance.
      fill(1, 16'h0040);
      run_row(2, -1, "floor40");
      check("floor40 x_const", 32'(x_w[2]), 32'h0001);
      drain(2, 0, "floor40");
      fill(1, 16'h0000);
      run_row(2, 0, "floor0");
      drain(2, 0, "floor0");

      // Short row: in_last arrives on the 3rd sample, and len_err is sticky.
      fill(3, 16'h8000);
      run_row(0, 2, "short");
      check("short x_const", 32'(x_w[0]), 32'h0300);
      check("short len_err_set", 32'(len_err_w[0]), 1);
      drain(0, 0, "short");
      fill(4, 16'h8000);
      run_row(0, 3, "after_short");
      check("after_short len_err_sticky", 32'(len_err_w[0]), 1);
      drain(0, 0, "after_short");

      // Reset in the middle of a row.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1; in_exp[0] = 16'h8000; in_last[0] = 1'b0;
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      check("midrst partial_cnt", 32'(cnt_w[0]), 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < NI; g++) exp_err[g] = 1'b0;
      check("midrst row_cnt", 32'(cnt_w[0]), 0);
      check("midrst len_err", 32'(len_err_w[0]), 0);
      fill(4, 16'h4000);
      run_row(0, -1, "midrst");
      check("midrst x_const", 32'(x_w[0]), 32'h0200);
      drain(0, 0, "midrst");

      // Reset right after a handshake must flush the pending ln_valid pulse.
      fill(4, 16'h2000);
      run_row(0, 3, "flush");
      @(negedge clk);
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("flush ln_a", 32'(ln_valid_w[0]), 0);
      @(negedge clk);
      check("flush ln_b", 32'(ln_valid_w[0]), 0);
      check("flush out_valid", 32'(out_valid_w[0]), 0);

      // Random rows on the ROW_LEN=4 instance.
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 4));
         row_q.delete();
         for (int i = 0; i < n; i++) row_q.push_back(16'($urandom));
         if (n < 4) lp = n - 1;
         else lp = ($urandom_range(0, 1) == 1) ? 3 : -1;
         run_row(0, lp, $sformatf("rnd%0d", r));
         drain(0, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/exp_sum_accumulator.md
Name: exp_sum_accumulator

Overview:
Softmax denominator stage, directly upstream of the natural-log stage.
Accepts a row-wise stream of exponent values exp(x_i − max) in U1Q15 and accumulates one row's sum. Converts the sum to U8Q8 with saturation and a floor, then presents it to the log stage.
Generates a valid tag delayed by the log stage's fixed latency, aligned with the U3Q10 log result, which the log stage itself does not flag.

Parameters:
ROW_LEN, 64, nominal elements per row; legal range 1..255.
LN_LATENCY, 2, cycles from a stable log-stage input to its registered U3Q10 output.
CNT_W, 8, row-counter width; must hold ROW_LEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  exp sample valid
in_ready  output  1  accumulator can accept a sample
in_exp_U1Q15  input  16  exp sample, unsigned Q15 (0x8000 = 1.0); full 16-bit range accepted
in_last  input  1  marks the final sample of a row
out_valid  output  1  row sum available
out_ready  input  1  downstream accepts the sum
x_U8Q8  output  16  row sum, unsigned Q8, wired to the log stage input
ln_valid  output  1  one-cycle pulse; the log stage output corresponds to the handshaken sum
row_cnt  output  CNT_W  samples accepted in the current row
len_err  output  1  sticky; the row length differed from ROW_LEN

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; no other clock or reset exists.
- Reset values:
  - state = ACC, accumulator = 0, row_cnt = 0.
  - out_valid = 0, x_U8Q8 = 0x0000, ln_valid = 0, len_err = 0.
  - Delay pipe all 0.
  - in_ready = 0 while rst_n is low.
- FSM has two states, ACC and HOLD.
- ACC:
  - in_ready = 1. A sample is accepted when in_valid & in_ready.
  - Each accepted sample: acc (24-bit, U9Q15) += in_exp_U1Q15; row_cnt += 1.
  - Row closes on the accepted sample where in_last = 1 or row_cnt + 1 = ROW_LEN, whichever comes first.
  - If in_last and the count boundary disagree, len_err sets on the closing cycle and stays set until reset.
- On row close, computed from the sum including the closing sample:
  - t = (acc + sample) >> 7, a 17-bit U9Q8 value (truncation).
  - If t > 0xFFFF, x_U8Q8 = 0xFFFF (saturate).
  - Else if t = 0, x_U8Q8 = 0x0001 (floor; log of 0 is undefined).
  - Else x_U8Q8 = t[15:0].
  - Next cycle: state = HOLD, out_valid = 1.
- HOLD:
  - in_ready = 0.
  - x_U8Q8 and out_valid stay stable until out_ready = 1.
  - On handshake (out_valid & out_ready): acc = 0, row_cnt = 0, out_valid = 0, state = ACC next cycle.
  - x_U8Q8 keeps its last value until the next row closes.
- ln_valid:
  - A LN_LATENCY-deep shift register loaded with the handshake event.
  - ln_valid pulses exactly LN_LATENCY cycles after the handshake cycle. It is aligned with the log stage output for the x_U8Q8 held at the handshake.
  - Back-to-back rows produce independent pulses.
- Timing:
  - Minimum row-to-sum latency is 1 cycle after the closing sample.
  - Throughput is 1 sample/cycle within a row, plus at least 1 bubble cycle per row for HOLD.
- Width guarantee: 255 × 0xFFFF < 2^24, so the 24-bit accumulator never wraps; only the output saturates.
- Reset mid-row discards the partial sum and count. Reset during HOLD drops the pending sum and flushes in-flight ln_valid pulses.
- in_valid while in HOLD is ignored (not accepted). The sample is held upstream.

Test Plan:
- ROW_LEN=4, four samples of 0x8000, out_ready=1 → x_U8Q8=0x0400, out_valid 1 cycle after the 4th sample, ln_valid 2 cycles after the handshake, len_err=0.
- ROW_LEN=255, 255 samples of 0xFFFF → x_U8Q8=0xFFFF (saturated), acc never wraps.
- ROW_LEN=1, single sample 0x0040 → t=0 → x_U8Q8=0x0001; single sample 0x0000 → 0x0001.
- ROW_LEN=4, in_last on the 3rd sample (each 0x8000) → x_U8Q8=0x0300, len_err=1 and stays 1 across the next correct row.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → in_ready=0, x_U8Q8 stable, no ln_valid until 2 cycles after out_ready rises.
- Reset mid-row: accept 2 samples of 0x8000, pull rst_n low for 1 cycle, then send a full 4-sample row of 0x4000 → x_U8Q8=0x0200, row_cnt restarts from 0.
